risc_processor_p: RTL and testbench
===================================

RISC_PROCESSOR_P -- requirements
Module: risc_processor_p

Interface
REQ-001 Parameter DW, default 16: data, register and address width; SHALL be >= 16.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Address  output  DW  memory address.
REQ-006 D_in  input  DW  read data; instructions occupy D_in[15:0].
REQ-007 D_Out  output  DW  write data.
REQ-008 mr_en  output  1  read strobe.
REQ-009 mw_en  output  1  write strobe.
REQ-010 mem_rdy  input  1  access complete this cycle; may be tied high for zero wait.
REQ-011 halted  output  1  core stopped by HLT.
REQ-012 status  output  8  {state[2:0], halted, 1'b0, C, N, Z}.

Function
REQ-013 State: 8 x DW registers r0-r7, all writable; PC (DW); IR (16); flags C, N, Z.
REQ-014 IR fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm9=[8:0], sign-extended to DW.
REQ-015 Opcodes: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs+~rt+1; 3 AND; 4 OR; 5 XOR; 6 SHL rd=rs<<1; 7 SHR rd=rs>>1 (logical); 8 LDI rd=imm9; 9 LD rd=mem[rs]; A ST mem[rs]=rd; B JMP pc=rd; C BZ; D BC; E BN; F HLT.
REQ-016 Flags update only on ops 1-7: Z=(result==0), N=result[DW-1]; C = carry-out for ADD/SUB, shifted-out bit for SHL/SHR, 0 for AND/OR/XOR; all other ops hold flags.
REQ-017 Branches C/D/E: when Z/C/N is set, pc=pc+imm9 (pc already incremented, modulo 2^DW); otherwise no effect.
REQ-018 FSM codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
REQ-019 FETCH: Address=PC, mr_en=1; on mem_rdy, IR<=D_in[15:0], PC<=PC+1 (wraps at 2^DW), go DECODE; otherwise stay.
REQ-020 DECODE: one cycle; go EXEC.
REQ-021 EXEC: ops 0-8 and B-E complete here and go FETCH; 9/A go MEM; F goes HALT.
REQ-022 MEM: Address=r[rs]; LD asserts mr_en, ST asserts mw_en with D_Out=r[rd]; hold until mem_rdy; on mem_rdy LD writes rd=D_in; go FETCH.
REQ-023 Address=PC and D_Out=0 in all states except MEM.
REQ-024 mr_en and mw_en are never both high, and both are forced low while reset is high.
REQ-025 HALT: no strobes; halted=1; state is held until reset.
REQ-026 Latency with mem_rdy held high: 3 cycles per instruction (FETCH, DECODE, EXEC); 4 for LD/ST; each wait cycle adds 1.
REQ-027 A register write and a read of the same register in the next instruction SHALL see the new value.

Reset
REQ-028 Reset applies in any state, including mid-access: state=FETCH, PC=RESET_PC, IR=0, r0-r7=0, flags=0, halted=0.
REQ-029 Outputs during reset: mr_en=0, mw_en=0, D_Out=0, Address=RESET_PC, status=8'h00.
REQ-030 First cycle after reset is released: mr_en=1, Address=RESET_PC.

Verification
REQ-031 DW=16, zero wait; program LDI r1,5; LDI r2,-5; ADD r3,r1,r2 -> r3=0, Z=1, C=1, N=0; ADD completes 9 cycles after reset release.
REQ-032 SUB r3,r1,r2 with r1=0, r2=1 -> r3=16'hFFFF, N=1, Z=0, C=0; then BN with imm9=-2 -> PC returns to the SUB address.
REQ-033 ST r1 to [r4=16'h0100], mem_rdy low for 2 MEM cycles -> mw_en high for exactly 3 cycles, Address=16'h0100, D_Out=5; a later LD into r5 reads 5.
REQ-034 HLT -> halted=1, status[7:5]=3'd4, no strobes for 20 cycles; then reset -> Address=RESET_PC and fetch restarts.
REQ-035 Reset asserted during a MEM cycle of an ST with mem_rdy low -> mw_en=0 in the same cycle; registers and PC cleared after the edge.
REQ-036 DW=32, RESET_PC=32'hFFFF_FFFF: first fetch at that address, PC wraps to 0; SHL of 32'h8000_0000 -> result 0, C=1, Z=1.

Source files
------------

// File: rtl/risc_processor_p.sv
`default_nettype none
// ============================================================================
// Module      : risc_processor_p
// Description : Multi-cycle 16-bit-instruction RISC core with a single
//               memory port (FETCH / DECODE / EXEC / MEM / HALT), eight
//               general registers, C/N/Z flags and a wait-state handshake.
// Revision    : 1.0  initial release
// ============================================================================
module risc_processor_p #(
  parameter int              DW       = 16,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [DW-1:0] Address,
  input  logic [DW-1:0] D_in,
  output logic [DW-1:0] D_Out,
  output logic          mr_en,
  output logic          mw_en,
  input  logic          mem_rdy,
  output logic          halted,
  output logic [7:0]    status
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_BZ  = 4'hC;
  localparam logic [3:0] OP_BC  = 4'hD;
  localparam logic [3:0] OP_BN  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  // Architectural state
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] regs_q [0:7];
  logic [DW-1:0] regs_d [0:7];
  logic          c_q, c_d;
  logic          n_q, n_d;
  logic          z_q, z_d;

  // Instruction fields and operand values
  logic [3:0]    op;
  logic [2:0]    rd_idx;
  logic [2:0]    rs_idx;
  logic [2:0]    rt_idx;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

  // ALU result
  logic [DW-1:0] alu_res;
  logic          alu_c;

  assign op      = ir_q[15:12];
  assign rd_idx  = ir_q[11:9];
  assign rs_idx  = ir_q[8:6];
  assign rt_idx  = ir_q[5:3];
  assign imm_ext = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
  assign rd_val  = regs_q[rd_idx];
  assign rs_val  = regs_q[rs_idx];
  assign rt_val  = regs_q[rt_idx];

  // Register all state; reset clears everything and points PC at RESET_PC
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Sequencer: memory phases wait on mem_rdy, HALT is sticky until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_HLT:       state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_rdy) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // ALU; carry of SUB is the carry-out of rs + ~rt + 1 (set when no borrow)
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: {alu_c, alu_res} = {1'b0, rs_val} + {1'b0, rt_val};
      OP_SUB: {alu_c, alu_res} = {1'b0, rs_val} + {1'b0, ~rt_val} + {{DW{1'b0}}, 1'b1};
      OP_AND: alu_res = rs_val & rt_val;
      OP_OR:  alu_res = rs_val | rt_val;
      OP_XOR: alu_res = rs_val ^ rt_val;
      OP_SHL: begin
        alu_res = {rs_val[DW-2:0], 1'b0};
        alu_c   = rs_val[DW-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, rs_val[DW-1:1]};
        alu_c   = rs_val[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Datapath next-state: instruction capture, register writeback, flags, PC
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    c_d  = c_q;
    n_d  = n_q;
    z_d  = z_q;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    case (state_q)
      S_FETCH: begin
        if (mem_rdy) begin
          ir_d = D_in[15:0];
          pc_d = pc_q + ONE;
        end
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            regs_d[rd_idx] = alu_res;
            z_d = (alu_res == '0);
            n_d = alu_res[DW-1];
            c_d = alu_c;
          end
          OP_LDI: regs_d[rd_idx] = imm_ext;
          OP_JMP: pc_d = rd_val;
          OP_BZ:  if (z_q) pc_d = pc_q + imm_ext;
          OP_BC:  if (c_q) pc_d = pc_q + imm_ext;
          OP_BN:  if (n_q) pc_d = pc_q + imm_ext;
          default: pc_d = pc_q;
        endcase
      end
      S_MEM: begin
        if (mem_rdy && (op == OP_LD)) begin
          regs_d[rd_idx] = D_in;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // Bus outputs; reset masks strobes and status and presents RESET_PC
  always_comb begin
    Address = pc_q;
    D_Out   = '0;
    mr_en   = 1'b0;
    mw_en   = 1'b0;
    halted  = 1'b0;
    status  = 8'h00;
    if (reset) begin
      Address = RESET_PC;
    end else begin
      case (state_q)
        S_FETCH: mr_en = 1'b1;
        S_MEM: begin
          Address = rs_val;
          if (op == OP_ST) begin
            mw_en = 1'b1;
            D_Out = rd_val;
          end else begin
            mr_en = 1'b1;
          end
        end
        S_HALT:  halted = 1'b1;
        default: mr_en = 1'b0;
      endcase
      status = {state_q, halted, 1'b0, c_q, n_q, z_q};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_processor_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_processor_p
// Description : Directed and randomized program bench for risc_processor_p
//               (DW=16 core plus a DW=32 core with RESET_PC at the top).
// Revision    : 1.0  initial release
// ============================================================================
module tb_risc_processor_p;

  logic clk;

  // 16-bit core
  logic        rst16, rdy16, mr16, mw16, halt16;
  logic [15:0] addr16, din16, dout16;
  logic [7:0]  stat16;
  logic [15:0] mem16 [0:1023];

  // 32-bit core
  logic        rst32, rdy32, mr32, mw32, halt32;
  logic [31:0] addr32, din32, dout32;
  logic [7:0]  stat32;
  logic [31:0] mem32 [0:15];

  // Reference model memory
  logic [15:0] m_mem [0:1023];

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;
  int st_wait  = 0;
  int mw_cycles = 0;
  int mw_bad    = 0;
  int strobe_cnt = 0;
  bit both_seen  = 0;

  assign din16 = mem16[addr16[9:0]];
  assign din32 = mem32[addr32[3:0]];

  risc_processor_p #(.DW(16), .RESET_PC(16'h0000)) u_dut16 (
    .clk(clk), .reset(rst16), .Address(addr16), .D_in(din16), .D_Out(dout16),
    .mr_en(mr16), .mw_en(mw16), .mem_rdy(rdy16), .halted(halt16), .status(stat16)
  );

  risc_processor_p #(.DW(32), .RESET_PC(32'hFFFF_FFFF)) u_dut32 (
    .clk(clk), .reset(rst32), .Address(addr32), .D_in(din32), .D_Out(dout32),
    .mr_en(mr32), .mw_en(mw32), .mem_rdy(rdy32), .halted(halt32), .status(stat32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 9'(imm)};
  endfunction

  // One clock: commit pending memory writes, pick mem_rdy, observe strobes
  task automatic step();
    logic        w16, w32;
    logic [9:0]  a16;
    logic [3:0]  a32;
    logic [15:0] d16;
    logic [31:0] d32;
    w16 = mw16 && rdy16;
    a16 = addr16[9:0];
    d16 = dout16;
    w32 = mw32 && rdy32;
    a32 = addr32[3:0];
    d32 = dout32;
    @(posedge clk);
    if (w16) mem16[a16] = d16;
    if (w32) mem32[a32] = d32;
    #1;
    case (rdy_mode)
      1: rdy16 = ($urandom_range(0, 2) != 0);
      2: begin
        if (mw16 && st_wait < 2) begin
          rdy16 = 1'b0;
          st_wait++;
        end else begin
          rdy16 = 1'b1;
        end
      end
      3: rdy16 = !mw16;
      default: rdy16 = 1'b1;
    endcase
    #1;
    if (mr16 && mw16) both_seen = 1;
    if (mw16 && addr16 == 16'h0100) begin
      mw_cycles++;
      if (dout16 !== 16'h0005) mw_bad++;
    end
  endtask

  task automatic do_reset16();
    rst16 = 1'b1;
    rdy16 = 1'b1;
    step();
    step();
    rst16 = 1'b0;
    rdy16 = 1'b1;
    #1;
  endtask

  task automatic run16(input int max_cyc, output int cyc);
    cyc = 0;
    while (halt16 !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    check("halt_reached", 64'(halt16), 64'(1));
  endtask

  task automatic clear_mem16();
    for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
  endtask

  // Instruction-level model: executes whole instructions, counts cycles per op
  task automatic model_run(output int cyc, output logic [2:0] flags);
    logic [15:0] r [0:7];
    logic [15:0] pc, ir, a, b, res, imm;
    logic [3:0]  op;
    logic        c, n, z;
    int unsigned sum;
    int          rd, rs, rt;
    for (int i = 0; i < 8; i++) r[i] = 16'h0;
    pc = 16'h0; c = 0; n = 0; z = 0; cyc = 0;
    for (int s = 0; s < 4000; s++) begin
      ir  = m_mem[pc[9:0]];
      pc  = pc + 16'd1;
      op  = ir[15:12];
      rd  = int'(ir[11:9]);
      rs  = int'(ir[8:6]);
      rt  = int'(ir[5:3]);
      imm = {{7{ir[8]}}, ir[8:0]};
      a   = r[rs];
      b   = r[rt];
      cyc += 3;
      if (op == 4'hF) break;
      if (op >= 4'h1 && op <= 4'h7) begin
        res = 16'h0;
        c   = 1'b0;
        case (op)
          4'h1: begin
            sum = 32'(a) + 32'(b);
            res = sum[15:0];
            c   = (sum > 32'd65535);
          end
          4'h2: begin res = a - b; c = (a >= b); end
          4'h3: res = a & b;
          4'h4: res = a | b;
          4'h5: res = a ^ b;
          4'h6: begin res = a << 1; c = a[15]; end
          default: begin res = a >> 1; c = a[0]; end
        endcase
        z = (res == 16'h0);
        n = res[15];
        r[rd] = res;
      end else begin
        case (op)
          4'h8: r[rd] = imm;
          4'h9: begin r[rd] = m_mem[a[9:0]]; cyc++; end
          4'hA: begin m_mem[a[9:0]] = r[rd]; cyc++; end
          4'hB: pc = r[rd];
          4'hC: if (z) pc = pc + imm;
          4'hD: if (c) pc = pc + imm;
          4'hE: if (n) pc = pc + imm;
          default: ;
        endcase
      end
    end
    flags = {c, n, z};
  endtask

  task automatic gen_random_program();
    int idx;
    int k;
    clear_mem16();
    idx = 0;
    mem16[idx] = enc_i(8, 6, 192); idx++;
    for (int j = 0; j < 24; j++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 3, 4: mem16[idx] = enc_r(int'($urandom_range(1, 7)), int'($urandom_range(0, 5)),
                                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        5: mem16[idx] = enc_i(8, int'($urandom_range(0, 5)), int'($urandom_range(0, 511)));
        6: mem16[idx] = enc_i(8, 6, 192 + int'($urandom_range(0, 63)));
        7: mem16[idx] = enc_r(9, int'($urandom_range(0, 5)), 6, 0);
        8: mem16[idx] = enc_r(10, int'($urandom_range(0, 7)), 6, 0);
        default: mem16[idx] = enc_i(int'($urandom_range(12, 14)), 0, int'($urandom_range(0, 3)));
      endcase
      idx++;
    end
    idx += 3;
    for (int i = 0; i < 7; i++) begin
      mem16[idx] = enc_i(8, 7, 128 + i); idx++;
      mem16[idx] = enc_r(10, i, 7, 0);   idx++;
    end
    mem16[idx] = enc_r(15, 0, 0, 0);
    for (int i = 192; i < 256; i++) mem16[i] = 16'($urandom);
    for (int i = 0; i < 1024; i++) m_mem[i] = mem16[i];
  endtask

  initial begin
    int          cyc;
    int          exp_cyc;
    logic [2:0]  exp_flags;

    rst16 = 1'b1; rdy16 = 1'b1;
    rst32 = 1'b1; rdy32 = 1'b1;
    clear_mem16();
    for (int i = 0; i < 16; i++) mem32[i] = 32'h0;

    // Outputs while reset is held
    #1;
    check("rst_mr_en",   64'(mr16),   64'(0));
    check("rst_mw_en",   64'(mw16),   64'(0));
    check("rst_dout",    64'(dout16), 64'(0));
    check("rst_addr",    64'(addr16), 64'(16'h0000));
    check("rst_status",  64'(stat16), 64'(8'h00));
    check("rst32_addr",  64'(addr32), 64'(32'hFFFF_FFFF));

    // LDI r1,5; LDI r2,-5; ADD r3,r1,r2; LDI r4,0x80; ST r3,[r4]; HLT
    mem16[0] = enc_i(8, 1, 5);
    mem16[1] = enc_i(8, 2, -5);
    mem16[2] = enc_r(1, 3, 1, 2);
    mem16[3] = enc_i(8, 4, 128);
    mem16[4] = enc_r(10, 3, 4, 0);
    mem16[5] = enc_r(15, 0, 0, 0);
    mem16[128] = 16'hDEAD;
    do_reset16();
    check("rel_mr_en", 64'(mr16),   64'(1));
    check("rel_addr",  64'(addr16), 64'(16'h0000));
    repeat (8) step();
    check("add_before_status", 64'(stat16), 64'(8'h40));
    step();
    check("add_done_status",   64'(stat16), 64'(8'h05));
    run16(100, cyc);
    check("add_r3_zero",  64'(mem16[128]), 64'(16'h0000));
    check("add_halt_status", 64'(stat16), 64'(8'h95));

    // LDI r1,0; LDI r2,1; SUB r3,r1,r2; BN -2 (loops back to SUB)
    clear_mem16();
    mem16[0] = enc_i(8, 1, 0);
    mem16[1] = enc_i(8, 2, 1);
    mem16[2] = enc_r(2, 3, 1, 2);
    mem16[3] = enc_i(14, 0, -2);
    do_reset16();
    repeat (9) step();
    check("sub_status", 64'(stat16), 64'(8'h02));
    repeat (3) step();
    check("bn_target_addr", 64'(addr16), 64'(16'h0002));
    check("bn_target_mr",   64'(mr16),   64'(1));

    // ST r1 to 0x100 with two wait cycles, then LD back into r5 and store it
    clear_mem16();
    mem16[0] = enc_i(8, 1, 5);
    mem16[1] = enc_i(8, 4, 128);
    mem16[2] = enc_r(1, 4, 4, 4);
    mem16[3] = enc_r(10, 1, 4, 0);
    mem16[4] = enc_r(9, 5, 4, 0);
    mem16[5] = enc_i(8, 6, 144);
    mem16[6] = enc_r(10, 5, 6, 0);
    mem16[7] = enc_r(15, 0, 0, 0);
    do_reset16();
    rdy_mode = 2; st_wait = 0; mw_cycles = 0; mw_bad = 0;
    run16(200, cyc);
    rdy_mode = 0;
    check("st_wait_cycles",  64'(cyc),         64'(29));
    check("st_mw_len",       64'(mw_cycles),   64'(3));
    check("st_addr_data",    64'(mw_bad),      64'(0));
    check("st_mem_word",     64'(mem16[256]),  64'(16'h0005));
    check("ld_r5_readback",  64'(mem16[144]),  64'(16'h0005));

    // HALT holds with no strobes, then reset restarts fetch
    strobe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mr16 || mw16) strobe_cnt++;
    end
    check("halt_no_strobes", 64'(strobe_cnt),  64'(0));
    check("halt_flag",       64'(halt16),      64'(1));
    check("halt_state",      64'(stat16[7:5]), 64'(3'd4));
    rst16 = 1'b1;
    #1;
    check("halt_rst_addr", 64'(addr16), 64'(16'h0000));
    step();
    rst16 = 1'b0;
    #1;
    check("halt_rel_mr",   64'(mr16),   64'(1));
    check("halt_rel_flag", 64'(halt16), 64'(0));

    // Reset during a stalled ST: strobe drops at once, state clears after the edge
    mem16[256] = 16'h1234;
    rdy_mode = 3;
    do_reset16();
    cyc = 0;
    while (mw16 !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    check("st_mem_reached", 64'(mw16), 64'(1));
    rst16 = 1'b1;
    clear_mem16();
    mem16[256] = 16'h1234;
    mem16[0] = enc_i(8, 7, 160);
    mem16[1] = enc_r(10, 1, 7, 0);
    mem16[2] = enc_i(8, 7, 161);
    mem16[3] = enc_r(10, 4, 7, 0);
    mem16[4] = enc_i(8, 7, 162);
    mem16[5] = enc_r(10, 5, 7, 0);
    mem16[6] = enc_r(15, 0, 0, 0);
    for (int i = 160; i < 163; i++) mem16[i] = 16'hFFFF;
    #1;
    check("midst_rst_mw",     64'(mw16),   64'(0));
    check("midst_rst_mr",     64'(mr16),   64'(0));
    check("midst_rst_dout",   64'(dout16), 64'(0));
    check("midst_rst_addr",   64'(addr16), 64'(16'h0000));
    check("midst_rst_status", 64'(stat16), 64'(8'h00));
    step();
    rst16 = 1'b0;
    rdy_mode = 0;
    rdy16 = 1'b1;
    #1;
    check("midst_pc_clear", 64'(addr16), 64'(16'h0000));
    run16(200, cyc);
    check("midst_no_write", 64'(mem16[256]), 64'(16'h1234));
    check("midst_r1_clear", 64'(mem16[160]), 64'(16'h0000));
    check("midst_r4_clear", 64'(mem16[161]), 64'(16'h0000));
    check("midst_r5_clear", 64'(mem16[162]), 64'(16'h0000));

    // Randomized programs against the instruction-level model
    for (int p = 0; p < 6; p++) begin
      gen_random_program();
      model_run(exp_cyc, exp_flags);
      do_reset16();
      rdy_mode = (p < 3) ? 0 : 1;
      run16(5000, cyc);
      rdy_mode = 0;
      if (p < 3) check($sformatf("rand%0d_cycles", p), 64'(cyc), 64'(exp_cyc));
      check($sformatf("rand%0d_status", p), 64'(stat16), 64'({3'd4, 1'b1, 1'b0, exp_flags}));
      for (int i = 128; i < 256; i++) begin
        check($sformatf("rand%0d_mem%0h", p, i), 64'(mem16[i]), 64'(m_mem[i]));
      end
    end

    // 32-bit core: first fetch at all-ones, PC wraps, SHL of 0x8000_0000
    mem32[15] = 32'(enc_i(8, 2, 8));
    mem32[0]  = 32'(enc_r(9, 1, 2, 0));
    mem32[1]  = 32'(enc_r(6, 3, 1, 0));
    mem32[2]  = 32'(enc_r(10, 3, 2, 0));
    mem32[3]  = 32'(enc_r(15, 0, 0, 0));
    mem32[8]  = 32'h8000_0000;
    check("w32_rst_status", 64'(stat32), 64'(8'h00));
    rst32 = 1'b0;
    #1;
    check("w32_first_addr", 64'(addr32), 64'(32'hFFFF_FFFF));
    check("w32_first_mr",   64'(mr32),   64'(1));
    repeat (3) step();
    check("w32_wrap_addr",  64'(addr32), 64'(32'h0000_0000));
    check("w32_wrap_mr",    64'(mr32),   64'(1));
    cyc = 3;
    while (halt32 !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    check("w32_halted",  64'(halt32),   64'(1));
    check("w32_cycles",  64'(cyc),      64'(17));
    check("w32_status",  64'(stat32),   64'(8'h95));
    check("w32_shl_res", 64'(mem32[8]), 64'(32'h0000_0000));

    check("strobe_exclusive", 64'(both_seen), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
